// File: rtl/div_seq_if.sv
// Purpose : Handshake bundle between the issue stage, the sequential divider
//           and its result consumer (writeback/ROB).
// Signals : in_valid/in_ready/in_funct3/in_rs1/in_rs2/in_tag  - op request
//           out_valid/out_ready/out_result/out_tag            - tagged result
// Modports: master - issue stage + consumer side (drives ops, takes results)
//           slave  - the divider itself
interface div_seq_if #(
    parameter int XLEN     = 32,
    parameter int TAG_BITS = 6
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_funct3;
    logic [XLEN-1:0]     in_rs1;
    logic [XLEN-1:0]     in_rs2;
    logic [TAG_BITS-1:0] in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_result;
    logic [TAG_BITS-1:0] out_tag;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/div_seq_unit.sv
// Purpose : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//           Accepts one op per ready/valid handshake, spends XLEN cycles on
//           shift-subtract steps (divide-by-zero and signed overflow finish in
//           one cycle) and returns the result with its ROB tag. A flush kills
//           any in-flight or held result.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           flush  - synchronous kill of the current op
//           bus    - div_seq_if.slave (op request in, tagged result out)
module div_seq_unit #(
    parameter int XLEN     = 32,
    parameter int TAG_BITS = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    div_seq_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement negate when cond is set.
    function automatic logic [XLEN-1:0] neg_if(input logic cond, input logic [XLEN-1:0] v);
        if (cond) begin
            return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [XLEN-1:0]     rem_q, rem_d;        // partial remainder
    logic [XLEN-1:0]     quo_q, quo_d;        // dividend shifting out / quotient shifting in
    logic [XLEN-1:0]     dvs_q, dvs_d;        // |divisor|
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                sel_rem_q, sel_rem_d;
    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     out_result_q, out_result_d;
    logic [TAG_BITS-1:0] out_tag_q, out_tag_d;

    logic                in_ready_s;
    logic                accept_s;
    logic                acc_uns_s, acc_rem_s, acc_div0_s, acc_ovf_s, acc_special_s;
    logic                acc_neg_quo_s, acc_neg_rem_s;
    logic [XLEN-1:0]     acc_special_res_s, acc_abs_a_s, acc_abs_b_s;
    logic [XLEN:0]       shifted_s, trial_s;
    logic [XLEN-1:0]     step_rem_s, step_quo_s, final_res_s;
    logic                unused_funct3_s;

    // funct3[2] is always 1 for M-extension divides; only [1:0] is decoded.
    assign unused_funct3_s = bus.in_funct3[2];

    assign in_ready_s = !flush && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_DONE) && bus.out_ready));
    assign accept_s   = bus.in_valid && in_ready_s;

    // Decode the incoming op: special-case detection, magnitudes and sign fixups.
    always_comb begin
        acc_uns_s     = bus.in_funct3[0];
        acc_rem_s     = bus.in_funct3[1];
        acc_div0_s    = (bus.in_rs2 == ZERO);
        acc_ovf_s     = !acc_uns_s && (bus.in_rs1 == INT_MIN) && (bus.in_rs2 == ALL_ONES);
        acc_special_s = acc_div0_s || acc_ovf_s;
        if (acc_div0_s) begin
            acc_special_res_s = acc_rem_s ? bus.in_rs1 : ALL_ONES;
        end else if (acc_rem_s) begin
            acc_special_res_s = ZERO;
        end else begin
            acc_special_res_s = INT_MIN;
        end
        acc_neg_rem_s = !acc_uns_s && bus.in_rs1[XLEN-1];
        acc_neg_quo_s = !acc_uns_s && (bus.in_rs1[XLEN-1] ^ bus.in_rs2[XLEN-1]);
        acc_abs_a_s   = neg_if(!acc_uns_s && bus.in_rs1[XLEN-1], bus.in_rs1);
        acc_abs_b_s   = neg_if(!acc_uns_s && bus.in_rs2[XLEN-1], bus.in_rs2);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The partial remainder is always below the divisor, so XLEN+1 bits hold
    // the shifted value and the top bit of the trial difference is the borrow.
    always_comb begin
        shifted_s = {rem_q, quo_q[XLEN-1]};
        trial_s   = shifted_s - {1'b0, dvs_q};
        if (!trial_s[XLEN]) begin
            step_rem_s = trial_s[XLEN-1:0];
            step_quo_s = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            step_rem_s = shifted_s[XLEN-1:0];
            step_quo_s = {quo_q[XLEN-2:0], 1'b0};
        end
        if (sel_rem_q) begin
            final_res_s = neg_if(neg_rem_q, step_rem_s);
        end else begin
            final_res_s = neg_if(neg_quo_q, step_quo_s);
        end
    end

    // Next-state logic: flush beats everything, then a new op, then sequencing.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        sel_rem_d    = sel_rem_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_tag_d = bus.in_tag;
            sel_rem_d = acc_rem_s;
            if (acc_special_s) begin
                out_result_d = acc_special_res_s;
                out_valid_d  = 1'b1;
                count_d      = {CNT_W{1'b0}};
                state_d      = ST_DONE;
            end else begin
                rem_d       = ZERO;
                quo_d       = acc_abs_a_s;
                dvs_d       = acc_abs_b_s;
                neg_quo_d   = acc_neg_quo_s;
                neg_rem_d   = acc_neg_rem_s;
                count_d     = CNT_W'(XLEN);
                out_valid_d = 1'b0;
                state_d     = ST_BUSY;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_BUSY: begin
                    rem_d   = step_rem_s;
                    quo_d   = step_quo_s;
                    count_d = count_q - CNT_W'(1);
                    // Last step: sign fixup is folded into the registered result.
                    if (count_q == CNT_W'(1)) begin
                        out_result_d = final_res_s;
                        out_valid_d  = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= {CNT_W{1'b0}};
            rem_q        <= ZERO;
            quo_q        <= ZERO;
            dvs_q        <= ZERO;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            sel_rem_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= ZERO;
            out_tag_q    <= {TAG_BITS{1'b0}};
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            sel_rem_q    <= sel_rem_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Testbench for div_seq_unit: directed RV32M cases, randomized ops, output
// back-pressure, flush and asynchronous reset. Expected results come from an
// arithmetic reference model and are queued at accept time; a monitor pops and
// compares on every result handshake.
module tb_div_seq_unit;

    localparam int XLEN     = 32;
    localparam int TAG_BITS = 6;
    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    div_seq_if #(.XLEN(XLEN), .TAG_BITS(TAG_BITS)) bus ();

    div_seq_unit #(.XLEN(XLEN), .TAG_BITS(TAG_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_res_q[$];
    logic [5:0]  exp_tag_q[$];
    logic [31:0] mon_res;
    logic [5:0]  mon_tag;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: RISC-V M semantics with wide signed arithmetic.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            return f3[1] ? a : 32'hFFFF_FFFF;
        end
        if (f3[0]) begin
            return f3[1] ? (a % b) : (a / b);
        end
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return f3[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            return 1;
        end
        return 33;
    endfunction

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present an op (caller is at posedge+1); optionally wait for and time the result.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input bit wait_done, output int attempts);
        int lat;
        bit got;
        bus.in_valid  = 1'b1;
        bus.in_funct3 = f3;
        bus.in_rs1    = a;
        bus.in_rs2    = b;
        bus.in_tag    = tag;
        attempts = 0;
        got      = 1'b0;
        while (!got && attempts < 50) begin
            @(negedge clk);
            attempts++;
            if (bus.in_ready === 1'b1) begin
                got = 1'b1;
                exp_res_q.push_back(ref_div(f3, a, b));
                exp_tag_q.push_back(tag);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout f3=%0h a=%0h b=%0h", f3, a, b);
            return;
        end
        if (wait_done) begin
            lat = 0;
            while (lat < 100) begin
                @(negedge clk);
                lat++;
                if (bus.out_valid === 1'b1) break;
            end
            check("latency", 64'(lat), 64'(ref_lat(f3, a, b)));
        end
    endtask

    // Scoreboard monitor: every result handshake not killed by flush/reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && flush === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_res_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result got=%0h tag=%0h", bus.out_result, bus.out_tag);
            end else begin
                mon_res = exp_res_q.pop_front();
                mon_tag = exp_tag_q.pop_front();
                check("result", 64'(bus.out_result), 64'(mon_res));
                check("tag", 64'(bus.out_tag), 64'(mon_tag));
            end
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    initial begin
        op_t         dir[$];
        int          att;
        int          seen;
        logic [2:0]  f3;
        logic [31:0] a, b;

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_funct3 = F_DIV;
        bus.in_rs1    = 32'd0;
        bus.in_rs2    = 32'd0;
        bus.in_tag    = 6'd0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        step_cycle();

        // Directed cases, including divide-by-zero and signed overflow
        dir.push_back('{F_DIV,  32'd100,        32'd7});
        dir.push_back('{F_REM,  32'd100,        32'd7});
        dir.push_back('{F_REM,  32'hFFFF_FF9C,  32'd7});
        dir.push_back('{F_DIV,  32'hFFFF_FF9C,  32'd7});
        dir.push_back('{F_DIVU, 32'hFFFF_FFFF,  32'd2});
        dir.push_back('{F_DIVU, 32'h1234_5678,  32'd0});
        dir.push_back('{F_REMU, 32'd5,          32'd0});
        dir.push_back('{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF});
        dir.push_back('{F_REM,  32'h8000_0000,  32'hFFFF_FFFF});
        dir.push_back('{F_DIV,  32'd7,          32'hFFFF_FFFE});
        dir.push_back('{F_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFF});
        foreach (dir[i]) begin
            issue(dir[i].f3, dir[i].a, dir[i].b, 6'(i + 1), 1'b1, att);
            step_cycle();
        end

        // Randomized ops
        for (int n = 0; n < 40; n++) begin
            f3 = 3'd4 + 3'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(f3, a, b, 6'($urandom_range(0, 63)), 1'b1, att);
            step_cycle();
        end

        // Back-pressure: hold the result, then hand over with a new op in the same cycle
        bus.out_ready = 1'b0;
        issue(F_DIV, 32'd100, 32'd7, 6'd5, 1'b1, att);
        step_cycle();
        bus.in_valid  = 1'b1;
        bus.in_funct3 = F_REM;
        bus.in_rs1    = 32'd100;
        bus.in_rs2    = 32'd7;
        bus.in_tag    = 6'd6;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_result", 64'(bus.out_result), 64'd14);
            check("hold_tag", 64'(bus.out_tag), 64'd5);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            step_cycle();
        end
        bus.out_ready = 1'b1;
        issue(F_REM, 32'd100, 32'd7, 6'd6, 1'b1, att);
        check("b2b_accept_attempts", 64'(att), 64'd1);
        step_cycle();

        // Flush in the middle of a computation
        issue(F_DIV, 32'd123456, 32'd77, 6'd9, 1'b0, att);
        repeat (9) step_cycle();
        flush = 1'b1;
        exp_res_q.delete();
        exp_tag_q.delete();
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        step_cycle();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_flush_valid", 64'(bus.out_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        step_cycle();

        // Asynchronous reset in the middle of a computation
        issue(F_DIVU, 32'hDEAD_BEEF, 32'd3, 6'h2A, 1'b0, att);
        repeat (5) step_cycle();
        #2;
        rst_n = 1'b0;
        exp_res_q.delete();
        exp_tag_q.delete();
        #1;
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_result", 64'(bus.out_result), 64'd0);
        check("async_rst_tag", 64'(bus.out_tag), 64'd0);
        step_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_valid", 64'(bus.out_valid), 64'd0);
        step_cycle();

        // One more op after reset, then drain
        issue(F_REM, 32'hFFFF_FF9C, 32'd7, 6'd33, 1'b1, att);
        for (int k = 0; k < 100 && exp_res_q.size() != 0; k++) begin
            @(negedge clk);
        end
        check("scoreboard_drained", 64'(exp_res_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
